gb_i2s_tx: RTL and testbench

I2S transmitter that serialises the Game Boy core's 16-bit stereo audio (`left`/`right` from `boy`) onto a standard Philips I2S bus for an external codec. It runs in the `clk_gb` domain. It generates BCLK and LRCLK itself as the bus master and latches one stereo sample pair per frame. It sits between `boy`'s audio outputs and the board's audio codec pins.

---
 rtl/gb_audio_pkg.sv | 24 ++
 rtl/gb_i2s_bclk_gen.sv | 61 ++++++
 rtl/gb_i2s_tx.sv | 175 +++++++++++++++++
 tb/tb_gb_i2s_tx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_audio_pkg.sv
// -----------------------------------------------------------------------------
// gb_audio_pkg
// Shared constants and types for the Game Boy audio output path.
//   GB_CLK_DIV     : default clk cycles per BCLK half-period
//   GB_SAMPLE_BITS : default audio sample width
//   GB_SLOT_BITS   : default BCLKs per I2S channel slot
//   sample_t       : signed 16-bit audio sample as produced by the core
//   cnt_width()    : counter width helper that never returns zero
// Build option consumed by users of this package: GB_I2S_MONO_MIX_EN.
// -----------------------------------------------------------------------------
package gb_audio_pkg;

    localparam int GB_CLK_DIV     = 2;
    localparam int GB_SAMPLE_BITS = 16;
    localparam int GB_SLOT_BITS   = 32;

    typedef logic signed [15:0] sample_t;

    // Width needed to count 0..n-1; a count range of one still gets one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gb_i2s_bclk_gen.sv
// -----------------------------------------------------------------------------
// gb_i2s_bclk_gen
// Bit-clock generator for the I2S transmitter. A divider counts 0..CLK_DIV-1
// and toggles the registered BCLK each time it wraps.
// Ports:
//   clk  in  : system clock (clk_gb domain)
//   rst  in  : synchronous active-high reset
//   bclk out : registered bit clock
//   fall out : one-clk strobe, high in the cycle whose closing edge drives
//              bclk from 1 to 0, so consumers registering on that same edge
//              change in step with the falling BCLK
// Parameters:
//   CLK_DIV : clk cycles per BCLK half-period (>= 1)
// -----------------------------------------------------------------------------
module gb_i2s_bclk_gen
    import gb_audio_pkg::*;
#(
    parameter int CLK_DIV = GB_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall
);

    localparam int                DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             bclk_r;
    logic             wrap_s;

    // Divider terminal count and the derived fall strobe.
    always_comb begin
        wrap_s = 1'b0;
        fall   = 1'b0;
        if (div_cnt_r == DIV_LAST) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
        // bclk_r is 1 here, so the wrap edge takes it to 0.
        fall = wrap_s & bclk_r;
    end

    // Divider counter and BCLK register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= ~bclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    assign bclk = bclk_r;

endmodule

// File: rtl/gb_i2s_tx.sv
// -----------------------------------------------------------------------------
// gb_i2s_tx
// Philips I2S master transmitter for the Game Boy core's stereo audio. Generates
// BCLK and LRCLK, latches one stereo pair per frame and shifts it out MSB first,
// each sample left-justified in its slot and zero padded.
// Ports:
//   clk        in  : system clock (clk_gb)
//   rst        in  : synchronous active-high reset
//   left       in  : signed left sample, only sampled on the latch strobe
//   right      in  : signed right sample, only sampled on the latch strobe
//   sample_req out : one-clk pulse on the cycle the inputs are latched
//   i2s_bclk   out : bit clock
//   i2s_lrclk  out : word select, 0 = left, 1 = right (leads data by one BCLK)
//   i2s_sdata  out : serial data, MSB first, changes with BCLK falling
// Parameters: CLK_DIV, SAMPLE_BITS, SLOT_BITS (SLOT_BITS >= SAMPLE_BITS).
// Build option: GB_I2S_MONO_MIX_EN - both channels carry the floor average of
// left and right. Frame timing is identical with and without it.
// -----------------------------------------------------------------------------
module gb_i2s_tx
    import gb_audio_pkg::*;
#(
    parameter int CLK_DIV     = GB_CLK_DIV,
    parameter int SAMPLE_BITS = GB_SAMPLE_BITS,
    parameter int SLOT_BITS   = GB_SLOT_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [SAMPLE_BITS-1:0] left,
    input  logic signed [SAMPLE_BITS-1:0] right,
    output logic                          sample_req,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata
);

    localparam int               FRAME_BITS = 2 * SLOT_BITS;
    localparam int               CNT_W      = cnt_width(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT   = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_BITS);

    logic                   fall_s;
    logic                   bclk_s;

    logic [CNT_W-1:0]       bit_cnt_r;
    logic [SAMPLE_BITS-1:0] left_hold_r;
    logic [SAMPLE_BITS-1:0] right_hold_r;
    logic                   lrclk_r;
    logic                   sdata_r;
    logic                   req_r;

    logic [CNT_W-1:0]       bit_nxt_s;
    logic [CNT_W-1:0]       bit_ahead_s;
    logic [CNT_W-1:0]       idx_s;
    logic                   chan_s;
    logic                   latch_s;
    logic                   lrclk_nxt_s;
    logic [SAMPLE_BITS-1:0] word_s;
    logic [SAMPLE_BITS-1:0] shifted_s;
    logic                   sdata_nxt_s;
    logic [SAMPLE_BITS-1:0] load_left_s;
    logic [SAMPLE_BITS-1:0] load_right_s;

    gb_i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk  (clk),
        .rst  (rst),
        .bclk (bclk_s),
        .fall (fall_s)
    );

`ifdef GB_I2S_MONO_MIX_EN
    // Floor average of two signed samples; one extra bit makes overflow impossible.
    function automatic logic [SAMPLE_BITS-1:0] mono_mix(
        input logic [SAMPLE_BITS-1:0] a,
        input logic [SAMPLE_BITS-1:0] b
    );
        logic [SAMPLE_BITS:0] sum;
        sum = {a[SAMPLE_BITS-1], a} + {b[SAMPLE_BITS-1], b};
        // Dropping the LSB of the sign-extended sum is an arithmetic shift by one.
        return sum[SAMPLE_BITS:1];
    endfunction

    // Mono build: both channels load the mixed value.
    always_comb begin
        load_left_s  = mono_mix(left, right);
        load_right_s = load_left_s;
    end
`else
    // Stereo build: channels load independently.
    always_comb begin
        load_left_s  = left;
        load_right_s = right;
    end
`endif

    // Frame position after the coming fall event, and one bit beyond for LRCLK.
    always_comb begin
        bit_nxt_s   = {CNT_W{1'b0}};
        bit_ahead_s = {CNT_W{1'b0}};
        idx_s       = {CNT_W{1'b0}};
        chan_s      = 1'b0;
        latch_s     = 1'b0;
        lrclk_nxt_s = 1'b0;
        if (bit_cnt_r == CNT_LAST) begin
            bit_nxt_s = {CNT_W{1'b0}};
        end else begin
            bit_nxt_s = bit_cnt_r + CNT_W'(1);
        end
        if (bit_nxt_s == CNT_LAST) begin
            bit_ahead_s = {CNT_W{1'b0}};
            latch_s     = 1'b1;
        end else begin
            bit_ahead_s = bit_nxt_s + CNT_W'(1);
            latch_s     = 1'b0;
        end
        if (bit_nxt_s >= CNT_SLOT) begin
            chan_s = 1'b1;
            idx_s  = bit_nxt_s - CNT_SLOT;
        end else begin
            chan_s = 1'b0;
            idx_s  = bit_nxt_s;
        end
        // Word select looks one bit ahead so it leads the data by one BCLK.
        lrclk_nxt_s = (bit_ahead_s >= CNT_SLOT);
    end

    // Serial bit for the coming slot position; padding bits are zero.
    always_comb begin
        word_s      = {SAMPLE_BITS{1'b0}};
        shifted_s   = {SAMPLE_BITS{1'b0}};
        sdata_nxt_s = 1'b0;
        if (chan_s) begin
            word_s = right_hold_r;
        end else begin
            word_s = left_hold_r;
        end
        shifted_s = word_s << idx_s;
        if (idx_s < CNT_SAMPLE) begin
            sdata_nxt_s = shifted_s[SAMPLE_BITS-1];
        end else begin
            sdata_nxt_s = 1'b0;
        end
    end

    // Serial state, holding registers and output registers; all advance on fall events.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r    <= {CNT_W{1'b0}};
            left_hold_r  <= {SAMPLE_BITS{1'b0}};
            right_hold_r <= {SAMPLE_BITS{1'b0}};
            lrclk_r      <= 1'b0;
            sdata_r      <= 1'b0;
            req_r        <= 1'b0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_nxt_s;
            lrclk_r   <= lrclk_nxt_s;
            sdata_r   <= sdata_nxt_s;
            req_r     <= latch_s;
            if (latch_s) begin
                left_hold_r  <= load_left_s;
                right_hold_r <= load_right_s;
            end
        end else begin
            req_r <= 1'b0;
        end
    end

    assign sample_req = req_r;
    assign i2s_bclk   = bclk_s;
    assign i2s_lrclk  = lrclk_r;
    assign i2s_sdata  = sdata_r;

endmodule

// File: tb/tb_gb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_gb_i2s_tx
// Directed bench for gb_i2s_tx. dut0 uses the default CLK_DIV=2, dut1 uses
// CLK_DIV=1; both share clock, reset and sample inputs. Serial data is decoded
// on BCLK rising edges and compared with hand-built frames.
// -----------------------------------------------------------------------------
module tb_gb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] left = 16'h0000;
    logic [15:0] right = 16'h0000;
    logic        req0, bclk0, lr0, sd0;
    logic        req1, bclk1, lr1, sd1;

    int n_vec = 0;
    int n_err = 0;

    // Per-frame word select, MSB = first decoded bit: 31 zeros, 32 ones, 1 zero.
    localparam logic [127:0] LR_EXP = {64'h0000_0001_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE};

    always #5 clk = ~clk;

    gb_i2s_tx #(.CLK_DIV(2), .SAMPLE_BITS(16), .SLOT_BITS(32)) dut0 (
        .clk(clk), .rst(rst), .left(left), .right(right),
        .sample_req(req0), .i2s_bclk(bclk0), .i2s_lrclk(lr0), .i2s_sdata(sd0)
    );

    gb_i2s_tx #(.CLK_DIV(1), .SAMPLE_BITS(16), .SLOT_BITS(32)) dut1 (
        .clk(clk), .rst(rst), .left(left), .right(right),
        .sample_req(req1), .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1)
    );

    // Two consecutive frames: each slot is the sample followed by 16 zero bits.
    function automatic logic [127:0] frame2(input logic [15:0] l1, input logic [15:0] r1,
                                            input logic [15:0] l2, input logic [15:0] r2);
        return {l1, 16'h0000, r1, 16'h0000, l2, 16'h0000, r2, 16'h0000};
    endfunction

    // Count negedges until sample_req of the chosen DUT; -1 when the budget expires.
    task automatic wait_req(input int which, input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (((which == 0) ? req0 : req1) === 1'b1) begin
                cycles = c;
                break;
            end
        end
    endtask

    // Called just after sample_req: skip the trailing bit of the old frame, then
    // capture 128 bits (two frames) of sdata/lrclk on BCLK rising edges.
    task automatic decode(input int which, input int chg_at,
                          input logic [15:0] nl, input logic [15:0] nr,
                          output logic [127:0] data, output logic [127:0] lrv,
                          output int got);
        logic prev, b;
        int   r;
        bit   skipped;
        data    = 128'h0;
        lrv     = 128'h0;
        r       = 0;
        skipped = 1'b0;
        prev    = (which == 0) ? bclk0 : bclk1;
        for (int c = 0; c < 2000 && r < 128; c++) begin
            @(negedge clk);
            b = (which == 0) ? bclk0 : bclk1;
            if (b && !prev) begin
                if (!skipped) begin
                    skipped = 1'b1;
                end else begin
                    data[127-r] = (which == 0) ? sd0 : sd1;
                    lrv[127-r]  = (which == 0) ? lr0 : lr1;
                    r++;
                    if (r == chg_at) begin
                        left  = nl;
                        right = nr;
                    end
                end
            end
            prev = b;
        end
        got = r;
    endtask

    task automatic test_reset();
        int first0, first1, ones0;
        rst   = 1'b1;
        left  = 16'hA5F0;
        right = 16'h0F0F;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req0, bclk0, lr0, sd0} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outs_div2: got %b expected 0000", {req0, bclk0, lr0, sd0});
        end
        n_vec++;
        if ({req1, bclk1, lr1, sd1} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outs_div1: got %b expected 0000", {req1, bclk1, lr1, sd1});
        end
        rst    = 1'b0;
        first0 = -1;
        first1 = -1;
        ones0  = 0;
        for (int c = 1; c <= 400 && first0 < 0; c++) begin
            @(negedge clk);
            if (sd0 === 1'b1) ones0++;
            if (req0 === 1'b1) first0 = c;
            if (req1 === 1'b1 && first1 < 0) first1 = c;
        end
        n_vec++;
        if (first0 !== 252) begin
            n_err++;
            $display("FAIL first_req_div2: got %0d expected 252", first0);
        end
        n_vec++;
        if (first1 !== 126) begin
            n_err++;
            $display("FAIL first_req_div1: got %0d expected 126", first1);
        end
        n_vec++;
        if (ones0 !== 0) begin
            n_err++;
            $display("FAIL first_frame_zero: got %0d one-bits expected 0", ones0);
        end
    endtask

    task automatic test_stream();
        logic [127:0] d, l;
        int g;
        decode(0, -1, 16'h0000, 16'h0000, d, l, g);
        n_vec++;
        if (g !== 128) begin
            n_err++;
            $display("FAIL stream_bits: got %0d expected 128", g);
        end
        n_vec++;
        if (d !== frame2(16'hA5F0, 16'h0F0F, 16'hA5F0, 16'h0F0F)) begin
            n_err++;
            $display("FAIL stream_data: got %h expected %h", d,
                     frame2(16'hA5F0, 16'h0F0F, 16'hA5F0, 16'h0F0F));
        end
        n_vec++;
        if (l !== LR_EXP) begin
            n_err++;
            $display("FAIL stream_lrclk: got %h expected %h", l, LR_EXP);
        end
    endtask

    task automatic test_cadence();
        logic [127:0] d, l;
        int c, g;
        wait_req(0, 600, c);
        wait_req(0, 600, c);
        n_vec++;
        if (c !== 256) begin
            n_err++;
            $display("FAIL cadence_period: got %0d expected 256", c);
        end
        // Inputs change during the right slot of the first frame.
        decode(0, 40, 16'h1234, 16'h8001, d, l, g);
        n_vec++;
        if (d !== frame2(16'hA5F0, 16'h0F0F, 16'h1234, 16'h8001)) begin
            n_err++;
            $display("FAIL cadence_hold: got %h expected %h", d,
                     frame2(16'hA5F0, 16'h0F0F, 16'h1234, 16'h8001));
        end
        n_vec++;
        if (l !== LR_EXP) begin
            n_err++;
            $display("FAIL cadence_lrclk: got %h expected %h", l, LR_EXP);
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] d, l;
        int c, g;
        wait_req(0, 600, c);
        repeat (164) @(negedge clk);
        n_vec++;
        if ({dut0.bit_cnt_r, lr0} !== {6'd40, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_pos: got cnt %0d lr %b expected 40 1", dut0.bit_cnt_r, lr0);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({dut0.bit_cnt_r, req0, bclk0, lr0, sd0} !== {6'd0, 4'b0000}) begin
            n_err++;
            $display("FAIL midrst_clear: got cnt %0d outs %b expected 0 0000",
                     dut0.bit_cnt_r, {req0, bclk0, lr0, sd0});
        end
        left  = 16'h8001;
        right = 16'h7FFE;
        rst   = 1'b0;
        wait_req(0, 600, c);
        n_vec++;
        if (c !== 252) begin
            n_err++;
            $display("FAIL midrst_first_req: got %0d expected 252", c);
        end
        decode(0, -1, 16'h0000, 16'h0000, d, l, g);
        n_vec++;
        if (d !== frame2(16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE)) begin
            n_err++;
            $display("FAIL midrst_data: got %h expected %h", d,
                     frame2(16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE));
        end
    endtask

    task automatic test_latch_reset();
        int c;
        wait_req(0, 600, c);
        repeat (255) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({req0, bclk0, lr0, sd0} !== 4'b0000) begin
            n_err++;
            $display("FAIL latchrst_outs: got %b expected 0000", {req0, bclk0, lr0, sd0});
        end
        rst = 1'b0;
        wait_req(0, 600, c);
        n_vec++;
        if (c !== 252) begin
            n_err++;
            $display("FAIL latchrst_first_req: got %0d expected 252", c);
        end
    endtask

    task automatic test_clkdiv1();
        logic [127:0] d, l;
        logic prev, b;
        int c, g, first, period;
        left  = 16'hC3A5;
        right = 16'h5A3C;
        wait_req(1, 300, c);
        wait_req(1, 300, c);
        n_vec++;
        if (c !== 128) begin
            n_err++;
            $display("FAIL div1_frame: got %0d expected 128", c);
        end
        decode(1, -1, 16'h0000, 16'h0000, d, l, g);
        n_vec++;
        if (d !== frame2(16'hC3A5, 16'h5A3C, 16'hC3A5, 16'h5A3C)) begin
            n_err++;
            $display("FAIL div1_data: got %h expected %h", d,
                     frame2(16'hC3A5, 16'h5A3C, 16'hC3A5, 16'h5A3C));
        end
        n_vec++;
        if (l !== LR_EXP) begin
            n_err++;
            $display("FAIL div1_lrclk: got %h expected %h", l, LR_EXP);
        end
        prev   = bclk1;
        first  = -1;
        period = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            b = bclk1;
            if (b && !prev) begin
                if (first < 0) begin
                    first = k;
                end else begin
                    period = k - first;
                    break;
                end
            end
            prev = b;
        end
        n_vec++;
        if (period !== 2) begin
            n_err++;
            $display("FAIL div1_bclk_period: got %0d expected 2", period);
        end
    endtask

    task automatic test_mix();
        logic [127:0] d, l, e1, e2;
        int c, g;
`ifdef GB_I2S_MONO_MIX_EN
        e1 = frame2(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        e2 = frame2(16'hBFFF, 16'hBFFF, 16'hBFFF, 16'hBFFF);
`else
        e1 = frame2(16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001);
        e2 = frame2(16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF);
`endif
        left  = 16'h7FFF;
        right = 16'h0001;
        wait_req(0, 600, c);
        decode(0, -1, 16'h0000, 16'h0000, d, l, g);
        n_vec++;
        if (d !== e1) begin
            n_err++;
            $display("FAIL mix_pos: got %h expected %h", d, e1);
        end
        left  = 16'h8000;
        right = 16'hFFFF;
        wait_req(0, 600, c);
        decode(0, -1, 16'h0000, 16'h0000, d, l, g);
        n_vec++;
        if (d !== e2) begin
            n_err++;
            $display("FAIL mix_neg: got %h expected %h", d, e2);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_cadence();
        test_mid_reset();
        test_latch_reset();
        test_clkdiv1();
        test_mix();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
